// File: rtl/fft_pkg.sv
// fft_pkg: frame geometry and read-state type shared by the FFT module-1 input control
package fft_pkg;
  localparam int FRAME_LEN = 32;
  localparam int ADDR_W = $clog2(FRAME_LEN);
  typedef enum logic {IDLE, READ} mod1_rd_state_e;
endpackage

// File: rtl/pingpong_flags.sv
// pingpong_flags: full flags of the two input-buffer banks, set by the writer, cleared by the reader
module pingpong_flags
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       set_en,
  input  logic       set_bank,
  input  logic       clr_en,
  input  logic       clr_bank,
  output logic [1:0] full
);
  logic [1:0] set_vec;
  logic [1:0] clr_vec;
  assign set_vec = set_en ? (set_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_vec = clr_en ? (clr_bank ? 2'b10 : 2'b01) : 2'b00;
  // a completed write and a finished read touch different banks, so both updates apply independently
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) full <= 2'b00;
    else full <= (full & ~clr_vec) | set_vec;
  a_no_set_clr_same_bank: assert property (@(posedge clk) disable iff (!rstn)
    !(set_en && clr_en && set_bank == clr_bank));
  a_no_set_full_bank: assert property (@(posedge clk) disable iff (!rstn)
    !(set_en && full[set_bank]));
endmodule

// File: rtl/cu_mod1_in.sv
// cu_mod1_in: writes CBFP0 beats into a ping-pong buffer and replays full frames in stride-paired order
module cu_mod1_in
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_mod1,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              alert_mod1,
  output logic              busy,
  output logic              ovf_err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  logic [1:0] full;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic set_en;
  logic rd_last;
  mod1_rd_state_e state;
  assign wr_en = rstn & valid_mod1 & ~full[wr_bank];
  assign wr_addr = wr_cnt;
  assign set_en = wr_en & (wr_cnt == LAST);
  assign rd_en = state == READ;
  assign rd_last = rd_en & (rd_cnt == LAST);
  assign rd_addr = {rd_cnt[0], rd_cnt[ADDR_W-1:1]};
  assign alert_mod1 = rd_en & (rd_cnt == '0);
  assign busy = rd_en | (|full);
  pingpong_flags u_flags (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (set_en),
    .set_bank (wr_bank),
    .clr_en   (rd_last),
    .clr_bank (rd_bank),
    .full     (full)
  );
  // write counter and bank select; a beat aimed at a full bank is dropped and latched as overflow
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      wr_cnt  <= wr_en ? wr_cnt + 1'b1 : wr_cnt;
      wr_bank <= wr_bank ^ set_en;
      ovf_err <= ovf_err | (valid_mod1 & full[wr_bank]);
    end
  // read FSM: replay a full bank, chaining straight into the other bank when it is already full
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= rd_en ? ((rd_last & ~full[~rd_bank]) ? IDLE : READ) : (full[rd_bank] ? READ : IDLE);
      rd_cnt   <= rd_en ? rd_cnt + 1'b1 : '0;
      rd_bank  <= rd_bank ^ rd_last;
      rd_valid <= rd_en;
    end
endmodule

// File: tb/tb_cu_mod1_in.sv
// tb_cu_mod1_in: directed scoreboard bench for the module-1 input control
module tb_cu_mod1_in;
  import fft_pkg::*;
  typedef struct {logic bank; int addr;} wr_t;
  typedef struct {int cyc; logic bank; int addr; logic alert;} rd_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic valid_mod1 = 1'b0;
  logic wr_en, wr_bank, rd_en, rd_bank, rd_valid, alert_mod1, busy, ovf_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  wr_t wr_q[$];
  rd_t rd_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic prev_rd_en = 1'b0;
  cu_mod1_in dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_mod1 (valid_mod1),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .alert_mod1 (alert_mod1),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rstn) begin
      wr_t w;
      rd_t r;
      chk("rd_valid_lag", rd_valid, prev_rd_en);
      prev_rd_en <= rd_en;
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", wr_en, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_bank", wr_bank, w.bank);
          chk("wr_addr", wr_addr, w.addr);
        end
      end
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", rd_en, 0);
        else begin
          r = rd_q.pop_front();
          chk("rd_cycle", cyc, r.cyc);
          chk("rd_bank", rd_bank, r.bank);
          chk("rd_addr", rd_addr, r.addr);
          chk("alert_mod1", alert_mod1, r.alert);
        end
      end else chk("alert_idle", alert_mod1, 0);
    end else prev_rd_en <= 1'b0;
  end
  task automatic step(input logic v);
    @(posedge clk);
    #1;
    valid_mod1 = v;
  endtask
  task automatic send(input int base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      if (gap != 0 && i != 0 && i % gap == 0) step(1'b0);
      step(1'b1);
      w.bank = 1'(((base + i) / FRAME_LEN) % 2);
      w.addr = (base + i) % FRAME_LEN;
      wr_q.push_back(w);
    end
  endtask
  task automatic push_frame(input logic bank, input int start);
    for (int j = 0; j < FRAME_LEN; j++) begin
      rd_t r;
      r.cyc = start + j;
      r.bank = bank;
      r.addr = (j % 2) * (FRAME_LEN / 2) + j / 2;
      r.alert = (j == 0);
      rd_q.push_back(r);
    end
  endtask
  task automatic drain(input int limit);
    int k;
    k = 0;
    step(1'b0);
    while ((rd_q.size() != 0 || wr_q.size() != 0) && k < limit) begin
      step(1'b0);
      k++;
    end
    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    repeat (3) step(1'b0);
  endtask
  task automatic reset_dut();
    step(1'b0);
    rstn = 1'b0;
    #1;
    chk("reset_outputs", {wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, rd_valid, alert_mod1, busy, ovf_err}, 0);
    rd_q.delete();
    wr_q.delete();
    step(1'b0);
    rstn = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();
    s = cyc + 1;
    push_frame(1'b0, s + 33);
    send(0, 32, 0);
    drain(100);
    reset_dut();
    s = cyc + 1;
    push_frame(1'b0, s + 33);
    push_frame(1'b1, s + 65);
    send(0, 64, 0);
    drain(100);
    reset_dut();
    s = cyc + 1;
    push_frame(1'b0, s + 40);
    send(0, 32, 4);
    drain(100);
    reset_dut();
    s = cyc + 1;
    push_frame(1'b0, s + 33);
    push_frame(1'b1, s + 66);
    send(0, 32, 0);
    step(1'b0);
    send(32, 32, 0);
    step(1'b0);
    @(negedge clk);
    chk("t6_busy_bank1_full", busy, 1);
    drain(100);
    reset_dut();
    s = cyc + 1;
    push_frame(1'b0, s + 33);
    push_frame(1'b1, s + 65);
    send(0, 64, 0);
    step(1'b1);
    @(negedge clk);
    chk("t4_wr_blocked", wr_en, 0);
    chk("t4_ovf_before", ovf_err, 0);
    step(1'b0);
    @(negedge clk);
    chk("t4_ovf_set", ovf_err, 1);
    drain(100);
    chk("t4_ovf_sticky", ovf_err, 1);
    reset_dut();
    send(0, 17, 0);
    step(1'b1);
    rstn = 1'b0;
    #1;
    chk("t5_midframe_reset", {wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, rd_valid, alert_mod1, busy, ovf_err}, 0);
    wr_q.delete();
    step(1'b0);
    rstn = 1'b1;
    s = cyc + 1;
    push_frame(1'b0, s + 33);
    send(0, 32, 0);
    drain(100);
    chk("t5_ovf_clear", ovf_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
